// File: rtl/dispense_pkg.sv
// Shared types and default constants for the inlet dispense sequencer.
package dispense_pkg;

    localparam int VOL_W_D       = 8;
    localparam int SETTLE_W_D    = 16;
    localparam int PUMP_PERIOD_D = 4;
    localparam int VALVE_DLY_D   = 3;
    localparam int FIFO_DEPTH_D  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPEN   = 3'd1,
        PUMP   = 3'd2,
        CLOSE  = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic [VOL_W_D-1:0]    strokes;
        logic [SETTLE_W_D-1:0] settle;
    } cmd_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dispense_cmd_fifo.sv
// Synchronous command queue; flush has priority over push and pop.
module dispense_cmd_fifo
    import dispense_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_D,
    parameter type T     = cmd_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic           do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/inlet_dispense_ctrl.sv
// Inlet valve / stepper pump sequencer: runs queued stroke+settle commands one at a time.
module inlet_dispense_ctrl
    import dispense_pkg::*;
#(
    parameter int VOL_W       = VOL_W_D,
    parameter int SETTLE_W    = SETTLE_W_D,
    parameter int PUMP_PERIOD = PUMP_PERIOD_D,
    parameter int VALVE_DLY   = VALVE_DLY_D,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_D
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [VOL_W-1:0]            cmd_strokes,
    input  logic [SETTLE_W-1:0]         cmd_settle,
    input  logic                        abort,
    output logic                        valve_open,
    output logic                        pump_step,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [VOL_W-1:0]            strokes_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CNT_W = imax(SETTLE_W, $clog2(imax(PUMP_PERIOD, VALVE_DLY) + 1));

    typedef struct packed {
        logic [VOL_W-1:0]    strokes;
        logic [SETTLE_W-1:0] settle;
    } cmd_w_t;

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    cmd_w_t             cur, cur_n, head, wcmd;
    logic               pend, pend_n;
    logic [VOL_W-1:0]   sd_n;
    logic               step_n, pop, full, empty;

    assign cmd_ready = !full && !abort;
    assign wcmd      = '{strokes: cmd_strokes, settle: cmd_settle};

    dispense_cmd_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_w_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .flush (abort),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        pend_n  = pend;
        sd_n    = strokes_done;
        step_n  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            // DONE dispatches directly so the next command opens right after the pulse
            IDLE, DONE: begin
                pend_n  = 1'b0;
                state_n = IDLE;
                if (!empty && !abort) begin
                    pop   = 1'b1;
                    cur_n = head;
                    sd_n  = '0;
                    if (head.strokes == '0) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_W'(head.settle);
                    end else begin
                        state_n = OPEN;
                        cnt_n   = CNT_W'(VALVE_DLY);
                    end
                end
            end
            OPEN, PUMP: begin
                if (abort) begin
                    state_n = CLOSE;
                    cnt_n   = CNT_W'(VALVE_DLY);
                    pend_n  = 1'b1;
                end else if (cnt == CNT_W'(1)) begin
                    if (state == PUMP && strokes_done == cur.strokes) begin
                        state_n = CLOSE;
                        cnt_n   = CNT_W'(VALVE_DLY);
                    end else begin
                        state_n = PUMP;
                        cnt_n   = CNT_W'(PUMP_PERIOD);
                        step_n  = 1'b1;
                        sd_n    = strokes_done + VOL_W'(1);
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            CLOSE: begin
                pend_n = pend || abort;
                if (cnt == CNT_W'(1)) begin
                    if (pend_n || cur.settle == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = SETTLE;
                        cnt_n   = CNT_W'(cur.settle);
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                // a zero settle still spends one cycle here
                if (abort) begin
                    state_n = DONE;
                    pend_n  = 1'b1;
                end else if (cnt <= CNT_W'(1)) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cur          <= '0;
            pend         <= 1'b0;
            strokes_done <= '0;
            valve_open   <= 1'b0;
            pump_step    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cur          <= cur_n;
            pend         <= pend_n;
            strokes_done <= sd_n;
            valve_open   <= (state_n == OPEN) || (state_n == PUMP);
            pump_step    <= step_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == DONE);
            aborted      <= (state_n == DONE) && pend_n;
        end
    end

endmodule

// File: tb/tb_inlet_dispense_ctrl.sv
// Directed bench for inlet_dispense_ctrl: single-command vector table plus multi-cycle corner sequences.
module tb_inlet_dispense_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_strokes;
    logic [15:0] cmd_settle;
    logic        abort;
    logic        valve_open, pump_step, busy, done, aborted;
    logic [7:0]  strokes_done;
    logic [2:0]  fifo_level;

    inlet_dispense_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_strokes  (cmd_strokes),
        .cmd_settle   (cmd_settle),
        .abort        (abort),
        .valve_open   (valve_open),
        .pump_step    (pump_step),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .strokes_done (strokes_done),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int strokes;
        int settle;
        int exp_done;
        int exp_pulses;
        int exp_valve;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   c, dc, np, nv, nd, ab, sd, k;
    int   b2b_str [5];
    int   b2b_set [5];
    logic prev_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // now sitting mid-cycle, well away from the rising edge
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3, 5, 25, 3, 15};
        vecs[1] = '{0, 0,  3, 0,  0};
        vecs[2] = '{1, 0, 12, 1,  7};
        vecs[3] = '{0, 4,  6, 0,  0};
        vecs[4] = '{2, 1, 17, 2, 11};
        b2b_str = '{1, 2, 1, 0, 1};
        b2b_set = '{0, 1, 0, 0, 2};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_strokes = '0; cmd_settle = '0; abort = 1'b0;
        tick();
        chk("rst_valve", valve_open, 0);
        chk("rst_pump", pump_step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_sd", strokes_done, 0);
        chk("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", cmd_ready, 1);

        // single commands from the table
        for (int v = 0; v < 5; v++) begin
            cmd_valid = 1'b1; cmd_strokes = 8'(vecs[v].strokes); cmd_settle = 16'(vecs[v].settle);
            tick();
            cmd_valid = 1'b0;
            c = 1; dc = -1; np = 0; nv = 0; ab = -1; sd = -1;
            while (c < 200 && dc < 0) begin
                if (valve_open) nv++;
                if (pump_step) np++;
                if (c == 2) chk($sformatf("v%0d_busy_c2", v), busy, 1);
                if (done) begin dc = c; ab = aborted; sd = strokes_done; end
                else begin tick(); c++; end
            end
            chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
            chk($sformatf("v%0d_pulses", v), np, vecs[v].exp_pulses);
            chk($sformatf("v%0d_valve_cycles", v), nv, vecs[v].exp_valve);
            chk($sformatf("v%0d_strokes_done", v), sd, vecs[v].strokes);
            chk($sformatf("v%0d_aborted", v), ab, 0);
            tick();
            chk($sformatf("v%0d_idle_after", v), busy, 0);
            chk($sformatf("v%0d_sd_held", v), strokes_done, vecs[v].strokes);
            tick();
        end

        // back-to-back: five pushes, then a push attempt against a full queue
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_strokes = 8'(b2b_str[i]); cmd_settle = 16'(b2b_set[i]);
            #1 chk($sformatf("b2b_ready%0d", i), cmd_ready, 1);
            tick();
        end
        for (int i = 5; i < 8; i++) begin
            cmd_strokes = 8'd7; cmd_settle = 16'd0;
            #1 chk($sformatf("b2b_full_ready_c%0d", i), cmd_ready, 0);
            chk($sformatf("b2b_level_c%0d", i), fifo_level, 4);
            tick();
        end
        cmd_valid = 1'b0;
        k = 0; prev_done = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (prev_done && k < 5) begin
                chk($sformatf("b2b_next_busy%0d", k), busy, 1);
                chk($sformatf("b2b_next_valve%0d", k), valve_open, (b2b_str[k] > 0) ? 1 : 0);
            end
            if (done) begin
                if (k < 5) chk($sformatf("b2b_order%0d", k), strokes_done, b2b_str[k]);
                k++;
            end
            prev_done = done;
            tick();
        end
        chk("b2b_done_count", k, 5);
        chk("b2b_idle", busy, 0);

        // abort in PUMP after two strokes, two commands queued
        nd = 0; np = 0; dc = -1; ab = -1; sd = -1;
        for (c = 0; c < 30; c++) begin
            cmd_valid   = (c <= 2);
            cmd_strokes = (c == 0) ? 8'd10 : 8'd1;
            cmd_settle  = (c == 0) ? 16'd5 : 16'd0;
            abort       = (c == 10);
            #1;
            if (pump_step) np++;
            if (c == 10) begin
                chk("ab_pump_pulses_before", np, 2);
                chk("ab_pump_ready", cmd_ready, 0);
                chk("ab_pump_level_before", fifo_level, 2);
            end
            if (c == 11) begin
                chk("ab_pump_level_after", fifo_level, 0);
                chk("ab_pump_valve_closed", valve_open, 0);
            end
            if (done) begin nd++; if (dc < 0) begin dc = c; ab = aborted; sd = strokes_done; end end
            tick();
        end
        cmd_valid = 1'b0; abort = 1'b0;
        chk("ab_pump_done_cycle", dc, 14);
        chk("ab_pump_aborted", ab, 1);
        chk("ab_pump_strokes", sd, 2);
        chk("ab_pump_total_pulses", np, 2);
        chk("ab_pump_done_count", nd, 1);
        chk("ab_pump_idle", busy, 0);

        // abort during SETTLE
        nd = 0; dc = -1; ab = -1;
        for (c = 0; c < 20; c++) begin
            cmd_valid = (c == 0); cmd_strokes = 8'd0; cmd_settle = 16'd10;
            abort = (c == 5);
            if (done) begin nd++; if (dc < 0) begin dc = c; ab = aborted; end end
            tick();
        end
        abort = 1'b0;
        chk("ab_settle_done_cycle", dc, 6);
        chk("ab_settle_aborted", ab, 1);
        chk("ab_settle_done_count", nd, 1);
        chk("ab_settle_idle", busy, 0);

        // abort in IDLE with a command waiting
        cmd_valid = 1'b1; cmd_strokes = 8'd2; cmd_settle = 16'd0;
        tick();
        cmd_valid = 1'b0;
        chk("ab_idle_level_before", fifo_level, 1);
        chk("ab_idle_busy_before", busy, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_level_after", fifo_level, 0);
        nd = 0; np = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) nd++;
            if (busy) np++;
            tick();
        end
        chk("ab_idle_no_done", nd, 0);
        chk("ab_idle_never_busy", np, 0);

        // asynchronous reset in the middle of PUMP
        for (c = 0; c < 5; c++) begin
            cmd_valid = (c <= 1); cmd_strokes = 8'd10; cmd_settle = 16'd0;
            tick();
        end
        cmd_valid = 1'b0;
        chk("rst_mid_pump_pulse", pump_step, 1);
        chk("rst_mid_pump_level", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valve", valve_open, 0);
        chk("rst_mid_pump", pump_step, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_sd", strokes_done, 0);
        tick();
        rst_n = 1'b1;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || valve_open) np++;
        end
        chk("rst_mid_stays_idle", np, 0);
        chk("rst_mid_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
